// File: rtl/rca_sched_pkg.sv
// Shared types and constants for the time-multiplexed ripple-carry scheduler.
package rca_sched_pkg;
  localparam int SLICE_W    = 3;
  localparam int NSLICE_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/rca.sv
// 3-bit ripple-carry adder built from a chain of full adders.
module rca (
  input  logic [2:0] i_a,
  input  logic [2:0] i_b,
  input  logic       i_cin,
  output logic [2:0] o_sum,
  output logic       o_cout
);
  logic [3:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < 3; i++) begin : g_fa
    assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout = w_c[3];
endmodule

// File: rtl/rca_sched.sv
// Two-requester adder service: one 3-bit slice adder reused over NSLICE cycles,
// with round-robin arbitration and a held response until accepted.
module rca_sched
  import rca_sched_pkg::*;
#(
  parameter int NSLICE = NSLICE_DEF,
  localparam int WIDTH = SLICE_W * NSLICE,
  localparam int KW    = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             cin0,
  input  logic             cin1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             busy
);
  state_t           r_state;
  logic             r_prio;
  logic [KW-1:0]    r_k;
  logic             r_carry;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_cin;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_id;
  logic             r_vld;
  logic             r_busy;

  logic             w_gnt;
  logic [2:0]       w_sa, w_sb, w_ss;
  logic             w_ci, w_co;
  int               w_lsb;

  // With both valid the pointer decides; otherwise the lone valid requester wins.
  assign w_gnt     = (req_valid == 2'b11) ? r_prio : req_valid[1];
  assign req_ready = (rst_n && r_state == IDLE && |req_valid) ?
                     (w_gnt ? 2'b10 : 2'b01) : 2'b00;

  assign w_lsb = SLICE_W * int'(r_k);
  assign w_sa  = r_a[w_lsb +: SLICE_W];
  assign w_sb  = r_b[w_lsb +: SLICE_W];
  assign w_ci  = (r_k == '0) ? r_cin : r_carry;

  rca u_rca (
    .i_a    (w_sa),
    .i_b    (w_sb),
    .i_cin  (w_ci),
    .o_sum  (w_ss),
    .o_cout (w_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_prio  <= 1'b0;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_id    <= 1'b0;
      r_vld   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req_ready) begin
            r_a     <= w_gnt ? a1   : a0;
            r_b     <= w_gnt ? b1   : b0;
            r_cin   <= w_gnt ? cin1 : cin0;
            r_id    <= w_gnt;
            r_prio  <= ~w_gnt;
            r_k     <= '0;
            r_busy  <= 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_sum[w_lsb +: SLICE_W] <= w_ss;
          r_carry <= w_co;
          if (r_k == KW'(NSLICE - 1)) begin
            r_k     <= '0;
            r_cout  <= w_co;
            r_vld   <= 1'b1;
            r_state <= RESP;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_vld   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = r_vld;
  assign rsp_sum   = r_sum;
  assign rsp_cout  = r_cout;
  assign rsp_id    = r_id;
  assign busy      = r_busy;
endmodule

// File: tb/tb_rca_sched.sv
// Directed bench for rca_sched: latency, arbitration, stall hold and mid-op reset.
module tb_rca_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [11:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        cin0 = 1'b0, cin1 = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_id;
  logic [11:0] rsp_sum;
  logic        rsp_cout;
  logic        busy;

  int nvec = 0;
  int nerr = 0;

  rca_sched #(.NSLICE(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .cin0(cin0), .cin1(cin1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_busy",  32'(busy), 0);
    chk("rst_vld",   32'(rsp_valid), 0);
    chk("rst_ready", 32'(req_ready), 0);
    step();
    rst_n = 1'b1;
  endtask

  // One full single-requester transaction, starting in an IDLE cycle.
  task automatic run_op(input string tag, input logic id, input logic [11:0] a,
                        input logic [11:0] b, input logic ci,
                        input logic [11:0] esum, input logic ecout);
    if (id) begin a1 = a; b1 = b; cin1 = ci; end
    else    begin a0 = a; b0 = b; cin0 = ci; end
    req_valid = id ? 2'b10 : 2'b01;
    #1;
    chk({tag, "_rdy"}, 32'(req_ready), id ? 2 : 1);
    step();
    // Disturb the requester after the handshake; the op must not notice.
    req_valid = 2'b00;
    a0 = ~a0; b0 = ~b0; a1 = ~a1; b1 = ~b1; cin0 = ~cin0; cin1 = ~cin1;
    chk({tag, "_busy"}, 32'(busy), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk({tag, "_early"}, 32'({rsp_valid, req_ready}), 0);
    end
    step();
    chk({tag, "_vld"},  32'(rsp_valid), 1);
    chk({tag, "_sum"},  32'(rsp_sum), 32'(esum));
    chk({tag, "_cout"}, 32'(rsp_cout), 32'(ecout));
    chk({tag, "_id"},   32'(rsp_id), 32'(id));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, "_drop"}, 32'({rsp_valid, busy}), 0);
  endtask

  initial begin
    do_reset();

    run_op("ovf",    1'b0, 12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1);
    run_op("ripple", 1'b1, 12'h1C7, 12'h039, 1'b0, 12'h200, 1'b0);
    run_op("mix",    1'b1, 12'hABC, 12'h123, 1'b1, 12'hBE0, 1'b0);

    // Both requesters valid right after reset, held high throughout.
    do_reset();
    a0 = 12'h111; b0 = 12'h222; cin0 = 1'b0;
    a1 = 12'h700; b1 = 12'h0FF; cin1 = 1'b1;
    req_valid = 2'b11;
    #1;
    chk("arb_first", 32'(req_ready), 1);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("arb_hold_rdy", 32'(req_ready), 0);
      step();
    end
    chk("arb_vld0", 32'(rsp_valid), 1);
    chk("arb_id0",  32'(rsp_id), 0);
    chk("arb_sum0", 32'(rsp_sum), 32'h333);
    rsp_ready = 1'b1;
    #1;
    chk("arb_resp_rdy", 32'(req_ready), 0);
    step();
    rsp_ready = 1'b0;
    chk("arb_idle_vld", 32'(rsp_valid), 0);
    chk("arb_second",   32'(req_ready), 2);
    step();
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) step();
    chk("arb_vld1",  32'(rsp_valid), 1);
    chk("arb_id1",   32'(rsp_id), 1);
    chk("arb_sum1",  32'(rsp_sum), 32'h800);
    chk("arb_cout1", 32'(rsp_cout), 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Response stall: outputs must hold while rsp_ready stays low.
    a0 = 12'h000; b0 = 12'h000; cin0 = 1'b1;
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 3; i++) begin
      chk("stall_vld", 32'(rsp_valid), 1);
      chk("stall_sum", 32'(rsp_sum), 32'h001);
      chk("stall_id",  32'(rsp_id), 0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("stall_done", 32'(rsp_valid), 0);

    // Reset while slice k=2 is being computed.
    a1 = 12'h555; b1 = 12'h555; cin1 = 1'b0;
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_vld",  32'(rsp_valid), 0);
    step();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("mid_quiet", 32'({rsp_valid, busy}), 0);
    end
    rsp_ready = 1'b0;
    run_op("post", 1'b0, 12'h800, 12'h800, 1'b1, 12'h001, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
